// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared constants, index-width helper and channel config record
package clkdiv_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int NCH_DEF   = 4;
  localparam int DIV_W_DEF = 16;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                 en;
    logic [DIV_W_DEF-1:0] div;
    logic [DIV_W_DEF-1:0] duty;
  } chan_cfg_t;

endpackage

// File: rtl/clkdiv_chan.sv
// rtl/clkdiv_chan.sv - one programmable divider channel (tick enable + square wave)
//
// Optional build macro: CLKDIV_DUTY_EN (adds cfg_duty; sq_o becomes count < P).
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   wr_i        config write addressed to this channel
//   cfg_div     divisor D (period D+1 cycles)
//   cfg_en      enable written alongside cfg_div
//   cfg_duty    duty threshold P (CLKDIV_DUTY_EN only)
//   sync_i      restart in phase if enabled
//   tick_o      one-cycle tick, high in the cycle after count==div
//   sq_o        square-wave output
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_en,
`ifdef CLKDIV_DUTY_EN
  input  logic [DIV_W-1:0] cfg_duty,
`endif
  input  logic             sync_i,
  output logic             tick_o,
  output logic             sq_o
);

  logic             en_q, en_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] shdw_q, shdw_d;
  logic             pend_q, pend_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             restart;
`ifdef CLKDIV_DUTY_EN
  logic [DIV_W-1:0] duty_q, duty_d;
  logic [DIV_W-1:0] dshdw_q, dshdw_d;
`else
  logic             sq_q, sq_d;
`endif

  always_comb begin
    en_d    = en_q;
    div_d   = div_q;
    shdw_d  = shdw_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    restart = 1'b0;
`ifdef CLKDIV_DUTY_EN
    duty_d  = duty_q;
    dshdw_d = dshdw_q;
`else
    sq_d    = sq_q;
`endif

    // Write handling comes first so that a same-cycle sync sees the new config.
    if (wr_i) begin
      if (!en_q) begin
        en_d    = cfg_en;
        div_d   = cfg_div;
        shdw_d  = cfg_div;
        pend_d  = 1'b0;
        cnt_d   = '0;
        restart = 1'b1;
`ifdef CLKDIV_DUTY_EN
        duty_d  = cfg_duty;
        dshdw_d = cfg_duty;
`else
        sq_d    = 1'b0;
`endif
      end else if (cfg_en) begin
        // Running channel: park the new divisor until the period boundary.
        shdw_d  = cfg_div;
        pend_d  = 1'b1;
`ifdef CLKDIV_DUTY_EN
        dshdw_d = cfg_duty;
`endif
      end else begin
        en_d    = 1'b0;
        pend_d  = 1'b0;
        cnt_d   = '0;
        restart = 1'b1;
`ifndef CLKDIV_DUTY_EN
        sq_d    = 1'b0;
`endif
      end
    end

    if (en_q && !restart) begin
      if (cnt_q == div_q) begin
        cnt_d  = '0;
        tick_d = 1'b1;
`ifndef CLKDIV_DUTY_EN
        sq_d   = ~sq_q;
`endif
        if (pend_d) begin
          div_d  = shdw_d;
          pend_d = 1'b0;
`ifdef CLKDIV_DUTY_EN
          duty_d = dshdw_d;
`endif
        end
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    if (sync_i && en_d) begin
      cnt_d  = '0;
      tick_d = 1'b0;
`ifndef CLKDIV_DUTY_EN
      sq_d   = 1'b0;
`endif
      if (pend_d) begin
        div_d  = shdw_d;
        pend_d = 1'b0;
`ifdef CLKDIV_DUTY_EN
        duty_d = dshdw_d;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q    <= 1'b0;
      div_q   <= '0;
      shdw_q  <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
`ifdef CLKDIV_DUTY_EN
      duty_q  <= '0;
      dshdw_q <= '0;
`else
      sq_q    <= 1'b0;
`endif
    end else begin
      en_q    <= en_d;
      div_q   <= div_d;
      shdw_q  <= shdw_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
`ifdef CLKDIV_DUTY_EN
      duty_q  <= duty_d;
      dshdw_q <= dshdw_d;
`else
      sq_q    <= sq_d;
`endif
    end
  end

  assign tick_o = tick_q;
`ifdef CLKDIV_DUTY_EN
  assign sq_o = en_q && (cnt_q < duty_q);
`else
  assign sq_o = sq_q;
`endif

endmodule

// File: rtl/clkdiv_multi.sv
// rtl/clkdiv_multi.sv - free-running counter plus NCH programmable divider channels
//
// Optional build macro: CLKDIV_DUTY_EN (adds cfg_duty port).
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   cnt_o       free-running CNT_W-bit counter, wraps to 0
//   cfg_we      one-cycle config write strobe
//   cfg_ch      channel index; out-of-range indices are ignored
//   cfg_div     divisor D, period D+1
//   cfg_en      channel enable
//   cfg_duty    duty threshold (CLKDIV_DUTY_EN only)
//   sync_i      restart all enabled channels in phase
//   tick_o      per-channel one-cycle tick
//   sq_o        per-channel square wave
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NCH   = NCH_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [CNT_W-1:0]      cnt_o,
  input  logic                  cfg_we,
  input  logic [ch_w(NCH)-1:0]  cfg_ch,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic                  cfg_en,
`ifdef CLKDIV_DUTY_EN
  input  logic [DIV_W-1:0]      cfg_duty,
`endif
  input  logic                  sync_i,
  output logic [NCH-1:0]        tick_o,
  output logic [NCH-1:0]        sq_o
);

  localparam int CH_W = ch_w(NCH);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic wr_sel;
    // Indices >= NCH match no channel, so such writes fall away here.
    assign wr_sel = cfg_we && (cfg_ch == CH_W'(i));

    clkdiv_chan #(.DIV_W(DIV_W)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .wr_i     (wr_sel),
      .cfg_div  (cfg_div),
      .cfg_en   (cfg_en),
`ifdef CLKDIV_DUTY_EN
      .cfg_duty (cfg_duty),
`endif
      .sync_i   (sync_i),
      .tick_o   (tick_o[i]),
      .sq_o     (sq_o[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb/tb_clkdiv_multi.sv - directed self-checking bench for clkdiv_multi
module tb_clkdiv_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cnt_o;
  logic       cfg_we;
  logic [2:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_en;
  logic [7:0] cfg_duty;
  logic       sync_i;
  logic [4:0] tick_o;
  logic [4:0] sq_o;

  int checks = 0;
  int errors = 0;

  clkdiv_multi #(.CNT_W(8), .NCH(5), .DIV_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .cnt_o    (cnt_o),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_en   (cfg_en),
`ifdef CLKDIV_DUTY_EN
    .cfg_duty (cfg_duty),
`endif
    .sync_i   (sync_i),
    .tick_o   (tick_o),
    .sq_o     (sq_o)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic wr(input int ch, input int d, input bit en, input int p);
    cfg_we   = 1'b1;
    cfg_ch   = 3'(ch);
    cfg_div  = 8'(d);
    cfg_en   = en;
    cfg_duty = 8'(p);
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic pulse_sync();
    sync_i = 1'b1;
    @(negedge clk);
    sync_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cnt_o !== 8'd0 || tick_o !== 5'd0 || sq_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_state cnt=%0d tick=%b sq=%b want 0/0/0", cnt_o, tick_o, sq_o);
    end
    rst = 1'b0;
    checks++;
    if (cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL release_cnt got %0d want 0", cnt_o);
    end
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk);
      checks++;
      if (cnt_o !== 8'(k) || tick_o !== 5'd0 || sq_o !== 5'd0) begin
        errors++;
        $display("FAIL free_run k=%0d cnt=%0d want %0d tick=%b sq=%b", k, cnt_o, 8'(k), tick_o, sq_o);
      end
    end
  endtask

  task automatic test_basic();
    wr(0, 4, 1'b1, 2);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if (tick_o[0] !== (k % 5 == 0) || tick_o[4:1] !== 4'd0) begin
        errors++;
        $display("FAIL basic_tick k=%0d tick=%b want ch0=%0d", k, tick_o, (k % 5 == 0));
      end
`ifndef CLKDIV_DUTY_EN
      checks++;
      if (sq_o[0] !== ((k / 5) % 2 == 1)) begin
        errors++;
        $display("FAIL basic_sq k=%0d got %b want %0d", k, sq_o[0], ((k / 5) % 2 == 1));
      end
`endif
    end
    wr(0, 4, 1'b0, 0);
  endtask

  task automatic test_glitch_free();
    wr(1, 9, 1'b1, 0);
    repeat (3) @(negedge clk);
    wr(1, 2, 1'b1, 0);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      checks++;
      if (tick_o[1] !== (k == 6 || (k > 6 && (k - 6) % 3 == 0))) begin
        errors++;
        $display("FAIL glitch_tick k=%0d got %b want %0d", k, tick_o[1],
                 (k == 6 || (k > 6 && (k - 6) % 3 == 0)));
      end
    end
    wr(1, 0, 1'b0, 0);
  endtask

  task automatic test_sync();
    wr(0, 3, 1'b1, 0);
    @(negedge clk);
    wr(2, 7, 1'b1, 0);
    repeat (2) @(negedge clk);
    pulse_sync();
    checks++;
    if (tick_o !== 5'd0) begin
      errors++;
      $display("FAIL sync_cycle_tick got %b want 00000", tick_o);
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if (tick_o[0] !== (k % 4 == 0) || tick_o[2] !== (k % 8 == 0) || tick_o[3] !== 1'b0) begin
        errors++;
        $display("FAIL sync_tick k=%0d tick=%b", k, tick_o);
      end
`ifndef CLKDIV_DUTY_EN
      checks++;
      if (sq_o[0] !== ((k / 4) % 2 == 1) || sq_o[2] !== ((k / 8) % 2 == 1) || sq_o[3] !== 1'b0) begin
        errors++;
        $display("FAIL sync_sq k=%0d sq=%b", k, sq_o);
      end
`endif
    end
    wr(0, 0, 1'b0, 0);
    wr(2, 0, 1'b0, 0);
  endtask

  task automatic test_edges();
    // D=0: tick every cycle
    wr(4, 0, 1'b1, 0);
    checks++;
    if (tick_o[4] !== 1'b0) begin
      errors++;
      $display("FAIL d0_first got %b want 0", tick_o[4]);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (tick_o[4] !== 1'b1) begin
        errors++;
        $display("FAIL d0_tick k=%0d got %b want 1", k, tick_o[4]);
      end
    end
    wr(4, 0, 1'b0, 0);

    // Out-of-range channel index
    wr(5, 1, 1'b1, 1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (tick_o !== 5'd0 || sq_o !== 5'd0) begin
        errors++;
        $display("FAIL oob_write k=%0d tick=%b sq=%b want 0", k, tick_o, sq_o);
      end
    end

    // Write and sync in the same cycle on a running channel
    wr(1, 2, 1'b1, 0);
    repeat (2) @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd5; cfg_en = 1'b1; cfg_duty = 8'd0;
    sync_i = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    sync_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (tick_o[1] !== (k == 6)) begin
        errors++;
        $display("FAIL wr_sync_tick k=%0d got %b want %0d", k, tick_o[1], (k == 6));
      end
    end
`ifndef CLKDIV_DUTY_EN
    checks++;
    if (sq_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_sq got %b want 1", sq_o[1]);
    end
`endif

    // Reset mid-period clears outputs immediately
    rst = 1'b1;
    #1;
    checks++;
    if (cnt_o !== 8'd0 || tick_o !== 5'd0 || sq_o !== 5'd0) begin
      errors++;
      $display("FAIL async_rst cnt=%0d tick=%b sq=%b want 0", cnt_o, tick_o, sq_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (tick_o !== 5'd0 || cnt_o !== 8'(k)) begin
        errors++;
        $display("FAIL post_rst k=%0d tick=%b cnt=%0d want 0/%0d", k, tick_o, cnt_o, k);
      end
    end
  endtask

`ifdef CLKDIV_DUTY_EN
  task automatic test_duty();
    wr(0, 9, 1'b1, 3);
    wr(1, 9, 1'b1, 0);
    wr(2, 9, 1'b1, 12);
    pulse_sync();
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (sq_o[0] !== (k % 10 < 3) || sq_o[1] !== 1'b0 || sq_o[2] !== 1'b1) begin
        errors++;
        $display("FAIL duty k=%0d sq=%b want ch0=%0d ch1=0 ch2=1", k, sq_o, (k % 10 < 3));
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_en = 1'b0;
    cfg_duty = '0; sync_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch_free();
    test_sync();
    test_edges();
`ifdef CLKDIV_DUTY_EN
    test_duty();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
- Parametrised successor to the free-running divider counter.
- Keeps a free-running CNT_W-bit count output for legacy consumers.
- Adds NCH independently programmable divider channels. Each channel produces a single-cycle tick enable and a square-wave output.
- Sits at the top of the board design. Feeds display scan, debounce, and slow-clock enables from one clk domain, with no derived clocks.

Parameters:
- CNT_W, 32, width of free-running counter cnt_o
- NCH, 4, number of divider channels (1..16)
- DIV_W, 16, width of per-channel divisor

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cnt_o  out  CNT_W  free-running counter, +1 per clk, wraps at 2^CNT_W-1 -> 0
- cfg_we  in  1  config write strobe, one cycle
- cfg_ch  in  max(1,$clog2(NCH))  channel index for write
- cfg_div  in  DIV_W  divisor D; channel period = D+1 cycles
- cfg_en  in  1  channel enable written alongside cfg_div
- sync_i  in  1  restart all enabled channels in phase
- tick_o  out  NCH  per-channel one-cycle tick
- sq_o  out  NCH  per-channel square wave
- cfg_duty  in  DIV_W  only when CLKDIV_DUTY_EN is defined

Behaviour:
- **Reset (async, rst=1):**
  - cnt_o=0; all channels disabled.
  - div=0, shadow=0, count=0, tick_o=0, sq_o=0.
  - No ticks while rst is high.
- **cnt_o:** increments every clk after reset release; pure wrap, no saturation.
- **Channel state:** en, div (active), shdw (pending), pend flag, count[DIV_W-1:0].
- **Enabled channel counting:**
  - count increments each cycle.
  - When count==div, count->0 next cycle and tick_o[ch] is asserted for exactly that cycle (registered; tick_o high in the cycle count==div is registered).
  - Tick rate: one tick every div+1 cycles. D=0 means tick_o held high every cycle.
- **sq_o (without CLKDIV_DUTY_EN):** toggles on every tick; period 2(D+1) cycles.
- **Config write (cfg_we=1, cfg_ch<NCH):**
  - Channel currently disabled: div, en load immediately; count=0; sq=0. First tick D+1 cycles later.
  - Channel enabled, cfg_en=1: cfg_div goes to shdw with pend=1. At the next wrap (count==div), div<=shdw and pend cleared. Current period is never truncated, so the change is glitch-free.
  - Channel enabled, cfg_en=0: disabled next cycle; count=0, tick=0, sq=0, pend cleared.
  - cfg_ch>=NCH: write ignored.
  - A second write before the pending one applies: shdw overwritten, last write wins.
- **sync_i=1:**
  - Every enabled channel: count<=0, sq<=0; no tick that cycle.
  - Pending shdw is applied immediately (div<=shdw).
  - Disabled channels are unaffected.
- **Simultaneous cfg_we and sync_i:** the write is processed first, then sync. The written channel restarts from count 0 using the new divisor, whether it was enabled or disabled.
- **Reset mid-period:** everything returns to reset values asynchronously; configuration is lost.

Optional Feature:
- Macro: CLKDIV_DUTY_EN.
- **Defined:**
  - Adds cfg_duty port and a per-channel duty register P, with an active/shadow pair written with div.
  - sq_o = (count < P) while enabled.
  - P=0 gives constant 0; P>div gives constant 1.
  - sq_o period is D+1.
- **Undefined:** no cfg_duty port; sq_o is the toggle-on-tick wave described above.
- tick_o behaviour is identical in both builds.

Decomposition:
- **Package clkdiv_pkg:**
  - Default constants CNT_W_DEF, NCH_DEF, DIV_W_DEF.
  - Channel-index width function.
  - Struct chan_cfg_t {en, div, duty}.
- **Sub-module clkdiv_chan (one divider channel):**
  - Holds count, active/shadow registers, tick/sq logic.
  - Top level instantiates NCH copies via generate.
  - Top level also contains the cnt_o counter and cfg_ch decode.

Test Plan:
- **Reset and free-run:** rst high 3 cycles, then release -> cnt_o = 0,1,2...; after 2^CNT_W cycles cnt_o=0 (check with CNT_W=8: 255->0); all tick_o/sq_o stay 0.
- **Basic divide:** write ch0 D=4, en=1 -> tick_o[0] every 5 cycles, first tick 5 cycles after write; sq_o[0] period 10, 50% duty.
- **Glitch-free update:** ch1 D=9 running; write D=2 at count=3 -> 10-cycle period completes, then ticks every 3 cycles; no short pulse.
- **Sync:** ch0 D=3 and ch2 D=7 at arbitrary phases; pulse sync_i -> both counts 0; ch0 ticks at +4 and ch2 at +8 cycles; disabled ch3 silent.
- **Edge cases:** D=0 -> tick_o continuously 1; write with cfg_ch=NCH -> no state change; cfg_we+sync_i same cycle on ch1 D=5 -> first tick exactly 6 cycles later; rst asserted mid-period -> outputs 0 in the same cycle.
- **DUTY build (CLKDIV_DUTY_EN):** D=9, P=3 -> sq_o high 3 of every 10 cycles; P=0 -> sq_o always 0; P=12 -> sq_o always 1.
